fpmult_normround: RTL

- Back end of the FP32 multiplier datapath.
- Consumes the split operand fields, the 48-bit significand product and the input-exception vector produced by the front-end preparation stage.
- Normalizes, rounds (round-to-nearest-even), resolves exceptions and packs the IEEE-754 single-precision result.
- 3-stage pipeline with valid/ready handshakes on both sides; sits between the significand multiplier and the result bus.

---
 rtl/fpmult_normround.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fpmult_normround.sv
// fpmult_normround: back end of the FP32 multiplier datapath.
// Takes the split operand fields, the 48-bit significand product and the
// input-exception vector. It normalizes and rounds the result to nearest-even,
// handles special operands and packs an IEEE-754 single-precision result.
// There are three pipeline stages (normalize, round, pack) with a global stall.
module fpmult_normround #(
  parameter int unsigned BIAS = 127,
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        Sa,
  input  logic        Sb,
  input  logic [7:0]  Ea,
  input  logic [7:0]  Eb,
  input  logic [47:0] Mp,
  input  logic [4:0]  InputExc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] P,
  output logic [3:0]  Flags
);

  localparam logic [9:0] BIAS_W = 10'(BIAS);

  // Global advance: every stage moves together unless the output is blocked.
  logic w_adv;

  // Stage 1 (normalize) combinational results
  logic        w_nSign;
  logic [9:0]  w_nExpSum;
  logic [9:0]  w_nExp;
  logic [22:0] w_nMan;
  logic        w_nGuard;
  logic        w_nSticky;

  // Stage 1 registers
  logic               r_s1Valid;
  logic               r_s1Sign;
  logic signed [9:0]  r_s1Exp;
  logic [22:0]        r_s1Man;
  logic               r_s1Guard;
  logic               r_s1Sticky;
  logic               r_s1ZeroA;
  logic               r_s1ZeroB;
  logic               r_s1NanA;
  logic               r_s1NanB;
  logic               r_s1InfA;
  logic               r_s1InfB;
  logic               r_s1Special;

  // Stage 2 (round) combinational results
  logic        w_roundUp;
  logic [23:0] w_manSum;
  logic [9:0]  w_rExp;
  logic [22:0] w_rMan;

  // Stage 2 registers
  logic               r_s2Valid;
  logic               r_s2Sign;
  logic signed [9:0]  r_s2Exp;
  logic [22:0]        r_s2Man;
  logic               r_s2Inexact;
  logic               r_s2ZeroA;
  logic               r_s2ZeroB;
  logic               r_s2NanA;
  logic               r_s2NanB;
  logic               r_s2InfA;
  logic               r_s2InfB;
  logic               r_s2Special;

  // Stage 3 (pack) combinational results
  logic [31:0] w_packP;
  logic [3:0]  w_packFlags;

  // Stage 3 / output registers
  logic        r_s3Valid;
  logic [31:0] r_p;
  logic [3:0]  r_flags;

  assign w_adv     = ~r_s3Valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_s3Valid;
  assign P         = r_p;
  assign Flags     = r_flags;

  // The product's sign is the XOR of the operand signs. The exponent sum is
  // kept to 10 bits, read as two's complement, so that underflow shows up
  // as a value <= 0.
  assign w_nSign   = Sa ^ Sb;
  assign w_nExpSum = {2'b00, Ea} + {2'b00, Eb} - BIAS_W;

  // Normalize: a product >= 2.0 shifts right by one and bumps the exponent;
  // otherwise the leading one is already at bit 46.
  always_comb begin
    w_nExp    = w_nExpSum;
    w_nMan    = Mp[45:23];
    w_nGuard  = Mp[22];
    w_nSticky = |Mp[21:0];
    if (Mp[47]) begin
      w_nExp    = w_nExpSum + 10'd1;
      w_nMan    = Mp[46:24];
      w_nGuard  = Mp[23];
      w_nSticky = |Mp[22:0];
    end
  end

  // Stage 1 register: capture the normalized fields and the operand class bits.
  // A zero exponent marks a zero or denormal operand, and both flush to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
    end else if (w_adv) begin
      r_s1Valid   <= in_valid;
      r_s1Sign    <= w_nSign;
      r_s1Exp     <= w_nExp;
      r_s1Man     <= w_nMan;
      r_s1Guard   <= w_nGuard;
      r_s1Sticky  <= w_nSticky;
      r_s1ZeroA   <= (Ea == 8'd0);
      r_s1ZeroB   <= (Eb == 8'd0);
      r_s1NanA    <= InputExc[3];
      r_s1NanB    <= InputExc[2];
      r_s1InfA    <= InputExc[1];
      r_s1InfB    <= InputExc[0];
      r_s1Special <= |InputExc;
    end
  end

  // Round to nearest-even: round up when the guard bit is set and the result
  // is either above the halfway point or odd at the tie.
  assign w_roundUp = r_s1Guard & (r_s1Sticky | r_s1Man[0]);
  assign w_manSum  = {1'b0, r_s1Man} + {23'd0, w_roundUp};

  // A carry out of the fraction means the significand rolled over to 2.0.
  // The fraction then becomes zero and the exponent goes up by one.
  always_comb begin
    w_rExp = r_s1Exp;
    w_rMan = w_manSum[22:0];
    if (w_manSum[23]) begin
      w_rExp = r_s1Exp + 10'sd1;
      w_rMan = 23'd0;
    end
  end

  // Stage 2 register: hold the rounded fields, the inexact indication and the
  // operand class bits forwarded from stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2Valid <= 1'b0;
    end else if (w_adv) begin
      r_s2Valid   <= r_s1Valid;
      r_s2Sign    <= r_s1Sign;
      r_s2Exp     <= w_rExp;
      r_s2Man     <= w_rMan;
      r_s2Inexact <= r_s1Guard | r_s1Sticky;
      r_s2ZeroA   <= r_s1ZeroA;
      r_s2ZeroB   <= r_s1ZeroB;
      r_s2NanA    <= r_s1NanA;
      r_s2NanB    <= r_s1NanB;
      r_s2InfA    <= r_s1InfA;
      r_s2InfB    <= r_s1InfB;
      r_s2Special <= r_s1Special;
    end
  end

  // Pack the result. Conditions are checked in priority order: NaN operands,
  // then inf*0, then infinity, then zero, then exponent overflow, then
  // exponent underflow (flush to zero), and finally a normal result.
  always_comb begin
    w_packP     = {r_s2Sign, r_s2Exp[7:0], r_s2Man};
    w_packFlags = {3'b000, r_s2Inexact};
    if (r_s2Special && (r_s2NanA || r_s2NanB)) begin
      w_packP     = QNAN;
      w_packFlags = 4'b0000;
    end else if (r_s2Special && (r_s2InfA || r_s2InfB) && (r_s2ZeroA || r_s2ZeroB)) begin
      w_packP     = QNAN;
      w_packFlags = 4'b1000;
    end else if (r_s2Special && (r_s2InfA || r_s2InfB)) begin
      w_packP     = {r_s2Sign, 8'hFF, 23'h0};
      w_packFlags = 4'b0000;
    end else if (r_s2ZeroA || r_s2ZeroB) begin
      w_packP     = {r_s2Sign, 31'h0};
      w_packFlags = 4'b0000;
    end else if (r_s2Exp >= 10'sd255) begin
      w_packP     = {r_s2Sign, 8'hFF, 23'h0};
      w_packFlags = 4'b0101;
    end else if (r_s2Exp <= 10'sd0) begin
      w_packP     = {r_s2Sign, 31'h0};
      w_packFlags = 4'b0011;
    end
  end

  // Output register: it loads only when the pipeline advances, so P and Flags
  // hold steady while the downstream stage is stalling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3Valid <= 1'b0;
      r_p       <= 32'h0;
      r_flags   <= 4'h0;
    end else if (w_adv) begin
      r_s3Valid <= r_s2Valid;
      r_p       <= w_packP;
      r_flags   <= w_packFlags;
    end
  end

endmodule
